// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle HI/LO multiply/divide unit for the E stage.
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous active-high reset; clears HI/LO and kills any in-flight op
//   start  - one-cycle request qualifying op (ignored while Busy)
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved
//   A, B   - forwarded rs/rt operands, captured on accept
//   Busy   - operation in progress (counter non-zero)
//   HI, LO - architectural HI/LO registers
module mult_div_unit #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Captured operation: bit 1 selects divide, bit 0 selects unsigned.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;

  logic signed [63:0] sa, sb, sb_nz;
  logic [63:0]        ua, ub, ub_nz;
  logic [31:0]        res_hi, res_lo;
  logic               div_zero;

  // Result datapath from the captured operands; divisor forced non-zero to keep
  // the arithmetic defined (a zero-divisor result is never written).
  always_comb begin
    sa       = {{32{a_q[31]}}, a_q};
    sb       = {{32{b_q[31]}}, b_q};
    ua       = {32'd0, a_q};
    ub       = {32'd0, b_q};
    div_zero = (b_q == 32'd0);
    sb_nz    = div_zero ? 64'sd1 : sb;
    ub_nz    = div_zero ? 64'd1 : ub;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (op_q)
      2'd0: {res_hi, res_lo} = sa * sb;
      2'd1: {res_hi, res_lo} = ua * ub;
      2'd2: begin
        // 64-bit signed divide so that 0x80000000 / -1 does not overflow.
        res_lo = 32'(sa / sb_nz);
        res_hi = 32'(sa % sb_nz);
      end
      default: begin
        res_lo = 32'(ua / ub_nz);
        res_hi = 32'(ua % ub_nz);
      end
    endcase
  end

  // Next-state: count down while busy, otherwise decode a new request.
  always_comb begin
    cnt_d = cnt_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && !(op_q[1] && div_zero)) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else if (start) begin
      case (op)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          a_d   = A;
          b_d   = B;
          op_d  = op[1:0];
          cnt_d = op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end
        3'd4:    hi_d = A;
        3'd5:    lo_d = A;
        default: ;
      endcase
    end
    busy_d = (cnt_d != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vectors plus randomized operations
// checked every cycle against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural HI/LO, cycles left, and the pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_wr = 1'b0;
  int          m_left = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one rising edge, computed with plain 64-bit arithmetic.
  task automatic model_edge(input bit r, input bit s, input logic [2:0] o,
                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (r) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (s) begin
      case (o)
        3'd0: begin p = longint'(sa * sb); p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = 5; end
        3'd1: begin p = ua * ub; p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = 5; end
        3'd2: begin
          p_wr = (b != 0); m_left = 10;
          if (p_wr) begin q = sa / sb; rm = sa % sb; p_lo = q[31:0]; p_hi = rm[31:0]; end
        end
        3'd3: begin
          p_wr = (b != 0); m_left = 10;
          if (p_wr) begin p = ua / ub; p_lo = p[31:0]; p = ua % ub; p_hi = p[31:0]; end
        end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle, advance the model, then compare Busy/HI/LO away from the edge.
  task automatic cyc(input bit r, input bit s, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b, input string tag);
    reset = r; start = s; op = o; A = a; B = b;
    @(posedge clk);
    model_edge(r, s, o, a, b);
    #1;
    chk({tag, ".busy"}, 32'(Busy), 32'(m_left != 0));
    chk({tag, ".hi"}, HI, m_hi);
    chk({tag, ".lo"}, LO, m_lo);
  endtask

  // Idle until the model's operation completes; start/op/A/B toggle randomly meanwhile.
  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (m_left == 0) break;
      cyc(1'b0, $urandom_range(0, 2) == 0, 3'($urandom), $urandom, $urandom, tag);
    end
    chk({tag, ".done"}, 32'(m_left), 32'd0);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input string tag);
    cyc(1'b0, 1'b1, o, a, b, tag);
    drain(tag);
  endtask

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, "rst");
    cyc(1'b1, 1'b1, 3'd0, 32'h5, 32'h7, "rst");
    chk("rst.hi_const", HI, 32'd0);
    chk("rst.lo_const", LO, 32'd0);

    // Signed multiply, then unsigned multiply back-to-back with zero bubble
    run(3'd0, 32'hFFFFFFFE, 32'd3, "mult");
    chk("mult.hi_const", HI, 32'hFFFFFFFF);
    chk("mult.lo_const", LO, 32'hFFFFFFFA);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu");
    chk("multu.hi_const", HI, 32'hFFFFFFFE);
    chk("multu.lo_const", LO, 32'h00000001);

    // Signed and unsigned divide of the same operands
    run(3'd2, 32'hFFFFFFF9, 32'd2, "div");
    chk("div.hi_const", HI, 32'hFFFFFFFF);
    chk("div.lo_const", LO, 32'hFFFFFFFD);
    run(3'd3, 32'hFFFFFFF9, 32'd2, "divu");
    chk("divu.hi_const", HI, 32'h00000001);
    chk("divu.lo_const", LO, 32'h7FFFFFFC);

    // Most-negative dividend over -1
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, "divovf");
    chk("divovf.lo_const", LO, 32'h80000000);
    chk("divovf.hi_const", HI, 32'h00000000);

    // mthi/mtlo on consecutive cycles, then divide by zero leaves them intact
    cyc(1'b0, 1'b1, 3'd4, 32'h12345678, 32'd0, "mthi");
    cyc(1'b0, 1'b1, 3'd5, 32'h9ABCDEF0, 32'd0, "mtlo");
    chk("mtx.hi_const", HI, 32'h12345678);
    chk("mtx.lo_const", LO, 32'h9ABCDEF0);
    chk("mtx.busy_const", 32'(Busy), 32'd0);
    run(3'd2, 32'd99, 32'd0, "div0");
    chk("div0.hi_const", HI, 32'h12345678);
    chk("div0.lo_const", LO, 32'h9ABCDEF0);

    // Reserved ops do nothing
    cyc(1'b0, 1'b1, 3'd6, 32'hDEADBEEF, 32'd1, "rsv6");
    cyc(1'b0, 1'b1, 3'd7, 32'hDEADBEEF, 32'd1, "rsv7");

    // Mult request in busy cycle 3 of a div is ignored
    cyc(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, "divbusy");
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, "divbusy");
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, "divbusy");
    cyc(1'b0, 1'b1, 3'd0, 32'd5, 32'd6, "divbusy");
    drain("divbusy");
    chk("divbusy.lo_const", LO, 32'd14);
    chk("divbusy.hi_const", HI, 32'd2);

    // Reset in busy cycle 2 of a mult abandons it
    cyc(1'b0, 1'b1, 3'd0, 32'd1234, 32'd5678, "mrst");
    cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, "mrst");
    cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, "mrst");
    chk("mrst.busy_const", 32'(Busy), 32'd0);
    chk("mrst.hi_const", HI, 32'd0);
    chk("mrst.lo_const", LO, 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 3'd0, $urandom, $urandom, "mrst.after");
    run(3'd1, 32'd3, 32'd4, "postrst");
    chk("postrst.lo_const", LO, 32'd12);

    // Randomized operations, including zero divisors and mid-op resets
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($signed(rb) >>> $urandom_range(0, 31));
      cyc(1'b0, 1'b1, ro, ra, rb, "rnd");
      if (m_left > 0 && $urandom_range(0, 9) == 0)
        cyc(1'b1, 1'b0, 3'd0, $urandom, $urandom, "rnd.rst");
      drain("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
